// File: rtl/lab8_top_if.sv
// Memory/I-O bus between the SimpleRISC CPU (master) and the memory block (slave).
//
// Bus timing: the master drives addr every cycle. When we is high, wdata is
// stored at addr on the rising edge. Read data for the address presented in
// cycle N is available on rdata throughout cycle N+1. There is no stall and
// no ready signal, so the master is never held off.
interface lab8_top_if;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic        we;
    logic [15:0] rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/lab8_top.sv
// SimpleRISC computer: multicycle 16-bit CPU, 256x16 RAM and memory-mapped
// switch/LED I/O. Optional macro LAB8_CALL_EN adds BL/BX/BLX on opcode 010;
// without it opcode 010 executes as a NOP. RAM contents come from the
// device image (or the testbench); reset never clears RAM or R0..R7.

module lab8_regfile (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [2:0]  wnum_i,
    input  logic [15:0] wdata_i,
    input  logic [2:0]  ra_i,
    input  logic [2:0]  rb_i,
    input  logic [2:0]  rc_i,
    output logic [15:0] ra_o,
    output logic [15:0] rb_o,
    output logic [15:0] rc_o
);
    logic [15:0] R0, R1, R2, R3, R4, R5, R6, R7;
    logic [15:0] rd_mux [0:7];

    // Single write port; registers deliberately have no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            case (wnum_i)
                3'd0: R0 <= wdata_i;
                3'd1: R1 <= wdata_i;
                3'd2: R2 <= wdata_i;
                3'd3: R3 <= wdata_i;
                3'd4: R4 <= wdata_i;
                3'd5: R5 <= wdata_i;
                3'd6: R6 <= wdata_i;
                default: R7 <= wdata_i;
            endcase
        end
    end

    // Gather the named registers so the three read ports can index them.
    always_comb begin
        rd_mux[0] = R0; rd_mux[1] = R1; rd_mux[2] = R2; rd_mux[3] = R3;
        rd_mux[4] = R4; rd_mux[5] = R5; rd_mux[6] = R6; rd_mux[7] = R7;
    end

    assign ra_o = rd_mux[ra_i];
    assign rb_o = rd_mux[rb_i];
    assign rc_o = rd_mux[rc_i];
endmodule

module lab8_dp (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] ir_i,
    input  logic        load_ab_i,
    input  logic        exec_i,
    input  logic        wr_en_i,
    input  logic [1:0]  wr_sel_i,
    input  logic [2:0]  wr_num_i,
    input  logic [15:0] mem_rdata_i,
    input  logic [8:0]  pc_i,
    output logic [15:0] a_o,
    output logic [15:0] rd_val_o,
    output logic        z_o,
    output logic        n_o,
    output logic        v_o
);
    logic [4:0]  opsub;
    logic [15:0] rn_val, rm_val, rm_sh, wdata;
    logic [15:0] a_q, b_q, c_q, c_d, diff;
    logic        z_q, n_q, v_q;

    assign opsub = ir_i[15:11];
    assign diff  = a_q - b_q;

    lab8_regfile REGFILE (
        .clk_i   (clk_i),
        .we_i    (wr_en_i),
        .wnum_i  (wr_num_i),
        .wdata_i (wdata),
        .ra_i    (ir_i[10:8]),
        .rb_i    (ir_i[2:0]),
        .rc_i    (ir_i[7:5]),
        .ra_o    (rn_val),
        .rb_o    (rm_val),
        .rc_o    (rd_val_o)
    );

    // Barrel stage on Rm only: none, LSL1, LSR1 (zero fill), ASR1.
    always_comb begin
        case (ir_i[4:3])
            2'b01:   rm_sh = {rm_val[14:0], 1'b0};
            2'b10:   rm_sh = {1'b0, rm_val[15:1]};
            2'b11:   rm_sh = {rm_val[15], rm_val[15:1]};
            default: rm_sh = rm_val;
        endcase
    end

    // ALU result for the instruction held in IR.
    always_comb begin
        case (opsub)
            5'b11010: c_d = {{8{ir_i[7]}}, ir_i[7:0]};
            5'b11000: c_d = b_q;
            5'b10100: c_d = a_q + b_q;
            5'b10101: c_d = diff;
            5'b10110: c_d = a_q & b_q;
            5'b10111: c_d = ~b_q;
            default:  c_d = 16'h0000;
        endcase
    end

    // Writeback source: ALU result, memory data, or return address for links.
    always_comb begin
        case (wr_sel_i)
            2'd1:    wdata = mem_rdata_i;
            2'd2:    wdata = {7'b0, pc_i};
            default: wdata = c_q;
        endcase
    end

    // Operand and result registers of the multicycle datapath.
    always_ff @(posedge clk_i) begin
        if (load_ab_i) begin
            a_q <= rn_val;
            b_q <= rm_sh;
        end
        if (exec_i) c_q <= c_d;
    end

    // Status flags change only on CMP; cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            z_q <= 1'b0;
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else if (exec_i && opsub == 5'b10101) begin
            z_q <= (diff == 16'h0000);
            n_q <= diff[15];
            v_q <= (a_q[15] ^ b_q[15]) & (diff[15] ^ a_q[15]);
        end
    end

    assign a_o = a_q;
    assign z_o = z_q;
    assign n_o = n_q;
    assign v_o = v_q;
endmodule

module lab8_cpu (
    input  logic       clk_i,
    input  logic       rst_n_i,
    lab8_top_if.master bus,
    output logic       halted_o
);
    localparam logic [3:0] S_RST  = 4'd0,  S_IF1  = 4'd1,  S_IF2  = 4'd2,
                           S_UPD  = 4'd3,  S_DEC  = 4'd4,  S_EXEC = 4'd5,
                           S_WB   = 4'd6,  S_ADDR = 4'd7,  S_MEM  = 4'd8,
                           S_LDWB = 4'd9,  S_BR   = 4'd10, S_CALL = 4'd11,
                           S_HALT = 4'd12;

    logic [3:0]  state_q, state_d;
    logic [8:0]  PC, addr_q, imm8_sx;
    logic [15:0] ir_q, a_val, rd_val;
    logic [2:0]  op;
    logic [1:0]  sub, wr_sel;
    logic [2:0]  wr_num;
    logic        load_ab, exec, wr_en, taken, z, n, v, unused_hi;

    assign op        = ir_q[15:13];
    assign sub       = ir_q[12:11];
    assign imm8_sx   = {ir_q[7], ir_q[7:0]};
    assign unused_hi = ^a_val[15:9];

    lab8_dp DP (
        .clk_i (clk_i), .rst_n_i (rst_n_i), .ir_i (ir_q),
        .load_ab_i (load_ab), .exec_i (exec), .wr_en_i (wr_en),
        .wr_sel_i (wr_sel), .wr_num_i (wr_num), .mem_rdata_i (bus.rdata),
        .pc_i (PC), .a_o (a_val), .rd_val_o (rd_val),
        .z_o (z), .n_o (n), .v_o (v)
    );

    // Branch condition from cond field IR[10:8]; unused codes never branch.
    always_comb begin
        case (ir_q[10:8])
            3'b000:  taken = 1'b1;
            3'b001:  taken = z;
            3'b010:  taken = ~z;
            3'b011:  taken = n ^ v;
            3'b100:  taken = (n ^ v) | z;
            default: taken = 1'b0;
        endcase
    end

    // Next-state logic of the fetch/decode/execute sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = S_IF1;
            S_IF1:  state_d = S_IF2;
            S_IF2:  state_d = S_UPD;
            S_UPD:  state_d = S_DEC;
            S_DEC: begin
                case (op)
                    3'b101, 3'b110: state_d = S_EXEC;
                    3'b011, 3'b100: state_d = (sub == 2'b00) ? S_ADDR : S_IF1;
                    3'b001:         state_d = S_BR;
                    3'b010:         state_d = S_CALL;
                    3'b111:         state_d = S_HALT;
                    default:        state_d = S_IF1;
                endcase
            end
            S_EXEC: state_d = ((op == 3'b101 && sub != 2'b01) ||
                               (op == 3'b110 && !sub[0])) ? S_WB : S_IF1;
            S_ADDR: state_d = S_MEM;
            S_MEM:  state_d = (op == 3'b011) ? S_LDWB : S_IF1;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF1;
        endcase
    end

    // Per-state datapath and bus controls; a reset edge suppresses writes.
    always_comb begin
        load_ab  = (state_q == S_DEC);
        exec     = (state_q == S_EXEC);
        wr_en    = 1'b0;
        wr_sel   = 2'd0;
        wr_num   = ir_q[7:5];
        bus.we   = 1'b0;
        bus.addr = PC;
        case (state_q)
            S_WB: begin
                wr_en = rst_n_i;
                if (op == 3'b110 && sub == 2'b10) wr_num = ir_q[10:8];
            end
            S_LDWB: begin
                wr_en  = rst_n_i;
                wr_sel = 2'd1;
            end
            S_MEM: begin
                bus.addr = addr_q;
                bus.we   = rst_n_i && (op == 3'b100);
            end
`ifdef LAB8_CALL_EN
            S_CALL: begin
                wr_en  = rst_n_i && sub[1];
                wr_sel = 2'd2;
                wr_num = 3'd7;
            end
`endif
            default: ;
        endcase
    end

    assign bus.wdata = rd_val;

    // State register; reset returns to RST from any state.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= S_RST;
        else          state_q <= state_d;
    end

    // PC, IR and data address; PC clears only on the first edge in RST after release.
    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            case (state_q)
                S_RST:  PC <= 9'd0;
                S_IF2:  ir_q <= bus.rdata;
                S_UPD:  PC <= PC + 9'd1;
                S_DEC:  ;
                S_ADDR: addr_q <= a_val[8:0] + {{4{ir_q[4]}}, ir_q[4:0]};
                S_BR:   if (sub == 2'b00 && taken) PC <= PC + imm8_sx;
`ifdef LAB8_CALL_EN
                S_CALL: begin
                    case (sub)
                        2'b11:        PC <= PC + imm8_sx;
                        2'b00, 2'b10: PC <= rd_val[8:0];
                        default:      ;
                    endcase
                end
`endif
                default: ;
            endcase
        end
    end

    assign halted_o = (state_q == S_HALT);
endmodule

module lab8_mem #(
    parameter int ADDR_W = 8
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    lab8_top_if.slave  bus,
    input  logic [7:0] sw_i,
    output logic [7:0] led_o
);
    logic [15:0] mem [0:(1 << ADDR_W) - 1];
    logic [15:0] ram_q, io_q;
    logic [7:0]  led_q;
    logic        ram_sel_q;

    // RAM occupies addr[8]==0: synchronous write, registered read.
    always_ff @(posedge clk_i) begin
        if (bus.we && !bus.addr[8]) mem[bus.addr[ADDR_W-1:0]] <= bus.wdata;
        ram_q <= mem[bus.addr[ADDR_W-1:0]];
    end

    // I/O page: switches readable at 0x140, LED register written at 0x100.
    always_ff @(posedge clk_i) begin
        ram_sel_q <= !bus.addr[8];
        io_q      <= (bus.addr == 9'h140) ? {8'b0, sw_i} : 16'h0000;
        if (!rst_n_i)                          led_q <= 8'h00;
        else if (bus.we && bus.addr == 9'h100) led_q <= bus.wdata[7:0];
    end

    assign bus.rdata = ram_sel_q ? ram_q : io_q;
    assign led_o     = led_q;
endmodule

module lab8_top #(
    parameter int ADDR_W = 8
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);
    lab8_top_if bus ();
    logic       halted, unused_inputs;
    logic [7:0] led;

    lab8_cpu CPU (
        .clk_i    (CLOCK_50),
        .rst_n_i  (KEY[1]),
        .bus      (bus),
        .halted_o (halted)
    );

    lab8_mem #(.ADDR_W(ADDR_W)) MEM (
        .clk_i   (CLOCK_50),
        .rst_n_i (KEY[1]),
        .bus     (bus),
        .sw_i    (SW[7:0]),
        .led_o   (led)
    );

    assign LEDR = {1'b0, halted, led};
    assign HEX0 = 7'h7F;
    assign HEX1 = 7'h7F;
    assign HEX2 = 7'h7F;
    assign HEX3 = 7'h7F;
    assign HEX4 = 7'h7F;
    assign HEX5 = 7'h7F;
    assign unused_inputs = ^{KEY[3:2], KEY[0], SW[9:8]};
endmodule

// File: tb/tb_lab8_top.sv
// Directed bench for the SimpleRISC computer: preloads programs into MEM,
// runs them to HALT and checks registers, memory, LEDs and reset behaviour.
module tb_lab8_top;
    logic       CLOCK_50;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [9:0] LEDR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int n_tests = 0;
    int n_fail  = 0;

    // Sum loop: count at 15, four values at 16..19, total stored at 20.
    logic [15:0] prog1 [0:20] = '{
        16'hD00F, 16'h6000, 16'hD100, 16'hD200, 16'hD310, 16'hD401,
        16'h63A0, 16'hA245, 16'hA364, 16'hA124, 16'hA900, 16'h23FA,
        16'hD614, 16'h8640, 16'hE000,
        16'd4, 16'd50, 16'd200, 16'd100, 16'd500, 16'hBADD};

    // I/O, shifts, CMP/BLT/BEQ, MVN, AND.
    logic [15:0] prog2 [0:20] = '{
        16'hD140, 16'hC029, 16'hC029, 16'hD2A5, 16'h8140, 16'hD540,
        16'hA1A5, 16'h6560, 16'h6181, 16'hD6FE, 16'hC0FE, 16'hC016,
        16'hA807, 16'h2301, 16'hD201, 16'hAF07, 16'h2101, 16'hD202,
        16'hB820, 16'hB6A0, 16'hE000};

    lab8_top dut (
        .CLOCK_50 (CLOCK_50),
        .KEY      (KEY),
        .SW       (SW),
        .LEDR     (LEDR),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5)
    );

    // Clock and reset block
    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_halt(input string tag);
        int n = 0;
        while (LEDR[8] !== 1'b1 && n < 3000) begin
            @(negedge CLOCK_50);
            n++;
        end
        check(tag, 64'(LEDR[8]), 64'd1);
    endtask

    task automatic wait_pc(input logic [8:0] target, input string tag);
        int n = 0;
        while (dut.CPU.PC !== target && n < 3000) begin
            @(negedge CLOCK_50);
            n++;
        end
        check(tag, 64'(dut.CPU.PC), 64'(target));
    endtask

    initial begin
        KEY = 4'b1101;
        SW  = 10'h33C;
        for (int i = 0; i < 21; i++) dut.MEM.mem[i] = prog1[i];
        @(negedge CLOCK_50);
        check("reset_ledr", 64'(LEDR), 64'h000);
        check("reset_hex", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'h3FF_FFFF_FFFF);

        // Sum loop run
        KEY[1] = 1'b1;
        run_halt("p1_halt");
        check("p1_pc", 64'(dut.CPU.PC), 64'h00F);
        check("p1_r0", 64'(dut.CPU.DP.REGFILE.R0), 64'd4);
        check("p1_r4", 64'(dut.CPU.DP.REGFILE.R4), 64'd1);
        check("p1_sum", 64'(dut.MEM.mem[20]), 64'd850);
        check("p1_ledr", 64'(LEDR), 64'h100);

        // Reset while halted
        KEY[1] = 1'b0;
        @(negedge CLOCK_50);
        check("halt_rst_ledr", 64'(LEDR), 64'h000);
        check("halt_rst_pc_frozen", 64'(dut.CPU.PC), 64'h00F);
        check("halt_rst_r4_kept", 64'(dut.CPU.DP.REGFILE.R4), 64'd1);
        dut.MEM.mem[20] = 16'hBADD;
        KEY[1] = 1'b1;
        @(negedge CLOCK_50);
        check("release_pc0", 64'(dut.CPU.PC), 64'h000);
        run_halt("rerun_halt");
        check("rerun_sum", 64'(dut.MEM.mem[20]), 64'd850);
        check("rerun_r0", 64'(dut.CPU.DP.REGFILE.R0), 64'd4);

        // BLT forced to a never-taken condition
        KEY[1] = 1'b0;
        @(negedge CLOCK_50);
        dut.MEM.mem[11] = 16'h27FA;
        dut.MEM.mem[20] = 16'hBADD;
        KEY[1] = 1'b1;
        run_halt("nt_halt");
        check("nt_sum", 64'(dut.MEM.mem[20]), 64'd50);
        check("nt_pc", 64'(dut.CPU.PC), 64'h00F);
        check("nt_r1", 64'(dut.CPU.DP.REGFILE.R1), 64'd1);

        // I/O and ALU program
        KEY[1] = 1'b0;
        @(negedge CLOCK_50);
        for (int i = 0; i < 21; i++) dut.MEM.mem[i] = prog2[i];
        KEY[1] = 1'b1;
        wait_pc(9'd14, "p2_reach_blt");
        check("cmp_n", 64'(dut.CPU.DP.n_q), 64'd1);
        check("cmp_v", 64'(dut.CPU.DP.v_q), 64'd1);
        check("cmp_z", 64'(dut.CPU.DP.z_q), 64'd0);
        run_halt("p2_halt");
        check("p2_ledr", 64'(LEDR), 64'h1A5);
        check("p2_r0_lsr", 64'(dut.CPU.DP.REGFILE.R0), 64'h7FFF);
        check("p2_r1_mvn", 64'(dut.CPU.DP.REGFILE.R1), 64'h8000);
        check("p2_r2_branches", 64'(dut.CPU.DP.REGFILE.R2), 64'h0001);
        check("p2_r3_sw", 64'(dut.CPU.DP.REGFILE.R3), 64'h003C);
        check("p2_r4_unmapped", 64'(dut.CPU.DP.REGFILE.R4), 64'h0000);
        check("p2_r5_and", 64'(dut.CPU.DP.REGFILE.R5), 64'h7FFE);
        check("p2_r7_asr", 64'(dut.CPU.DP.REGFILE.R7), 64'hFFFF);
        check("p2_pc", 64'(dut.CPU.PC), 64'h015);
        check("p2_z_equal", 64'(dut.CPU.DP.z_q), 64'd1);

        // Reset clears the LED register
        KEY[1] = 1'b0;
        @(negedge CLOCK_50);
        check("final_rst_ledr", 64'(LEDR), 64'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
